// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM-like N:1 arbiter.
package sram_arb_pkg;

  localparam int MAX_MST    = 8;
  localparam int MAX_ADDR_W = 64;
  localparam int MAX_DATA_W = 64;
  localparam int MAX_SIZE_W = 4;

  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Widest supported fields; the top zero-extends into these and slices back out.
  typedef struct packed {
    logic                  wr;
    logic [MAX_SIZE_W-1:0] size;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] wdata;
  } mst_req_t;

endpackage

// File: rtl/sram_arb_id_fifo.sv
// In-order FIFO of master IDs for accepted-but-unanswered requests.
module sram_arb_id_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [ID_W-1:0]         push_id,
  input  logic                    pop,
  output logic [ID_W-1:0]         head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][ID_W-1:0] mem_q, mem_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [PW:0]                cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/sram_like_arbiter.sv
// N-master to 1-slave SRAM-like bus arbiter with in-order response routing.
// Define SRAM_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module sram_like_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_MST  = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SIZE_W   = 2,
  parameter int MAX_OUTS = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_MST-1:0]          m_req,
  input  logic [NUM_MST-1:0]          m_wr,
  input  logic [NUM_MST*SIZE_W-1:0]   m_size,
  input  logic [NUM_MST*ADDR_W-1:0]   m_addr,
  input  logic [NUM_MST*DATA_W-1:0]   m_wdata,
  output logic [NUM_MST-1:0]          m_addr_ok,
  output logic [NUM_MST-1:0]          m_data_ok,
  output logic [DATA_W-1:0]           m_rdata,
  output logic                        s_req,
  output logic                        s_wr,
  output logic [SIZE_W-1:0]           s_size,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_wdata,
  input  logic                        s_addr_ok,
  input  logic                        s_data_ok,
  input  logic [DATA_W-1:0]           s_rdata,
  output logic [$clog2(MAX_OUTS):0]   outs_cnt,
  output logic                        proto_err
);

  localparam int ID_W = id_w(NUM_MST);

  logic [ID_W-1:0] gnt_id, lock_id_q, lock_id_d, head_id;
  logic            lock_vld_q, lock_vld_d;
  logic            proto_err_q, proto_err_d;
  logic            sel_req, fifo_full, fifo_empty, accept, pop;
  mst_req_t        sel;

`ifdef SRAM_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    int  idx;
    logic found;
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    if (lock_vld_q) begin
      gnt_id = lock_id_q;
    end else begin
      for (int k = 0; k < NUM_MST; k++) begin
        idx = (int'(rr_ptr_q) + k) % NUM_MST;
        if (!found && m_req[idx]) begin
          found  = 1'b1;
          gnt_id = ID_W'(idx);
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (gnt_id == ID_W'(NUM_MST-1)) ? '0 : gnt_id + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    gnt_id = '0;
    if (lock_vld_q) begin
      gnt_id = lock_id_q;
    end else begin
      for (int i = NUM_MST-1; i >= 0; i--)
        if (m_req[i]) gnt_id = ID_W'(i);
    end
  end
`endif

  always_comb begin
    sel_req = 1'b0;
    sel     = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (gnt_id == ID_W'(i)) begin
        sel_req    = m_req[i];
        sel.wr     = m_wr[i];
        sel.size   = MAX_SIZE_W'(m_size[i*SIZE_W +: SIZE_W]);
        sel.addr   = MAX_ADDR_W'(m_addr[i*ADDR_W +: ADDR_W]);
        sel.wdata  = MAX_DATA_W'(m_wdata[i*DATA_W +: DATA_W]);
      end
    end
  end

  // Full blocks new requests even when a pop lands in the same cycle.
  assign s_req   = sel_req & ~fifo_full & resetn;
  assign s_wr    = s_req & sel.wr;
  assign s_size  = s_req ? sel.size[SIZE_W-1:0]  : '0;
  assign s_addr  = s_req ? sel.addr[ADDR_W-1:0]  : '0;
  assign s_wdata = s_req ? sel.wdata[DATA_W-1:0] : '0;

  assign accept  = s_req & s_addr_ok;
  assign pop     = s_data_ok & ~fifo_empty & resetn;
  assign m_rdata = s_rdata;

  always_comb begin
    m_addr_ok = '0;
    m_data_ok = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      m_addr_ok[i] = accept & (gnt_id  == ID_W'(i));
      m_data_ok[i] = pop    & (head_id == ID_W'(i));
    end
  end

  // Lock pins the grant while the slave stalls; it survives full and withdrawn reqs.
  always_comb begin
    lock_vld_d  = lock_vld_q;
    lock_id_d   = lock_id_q;
    proto_err_d = proto_err_q | (s_data_ok & fifo_empty);
    if (accept) begin
      lock_vld_d = 1'b0;
    end else if (s_req) begin
      lock_vld_d = 1'b1;
      lock_id_d  = gnt_id;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_vld_q  <= 1'b0;
      lock_id_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      lock_vld_q  <= lock_vld_d;
      lock_id_q   <= lock_id_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;

  sram_arb_id_fifo #(
    .DEPTH (MAX_OUTS),
    .ID_W  (ID_W)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .push    (accept),
    .push_id (gnt_id),
    .pop     (pop),
    .head    (head_id),
    .count   (outs_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed table-driven bench for sram_like_arbiter (2 masters, 4 outstanding).
module tb_sram_like_arbiter;

`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk, resetn;
  logic [1:0]  m_req, m_wr, m_addr_ok, m_data_ok;
  logic [3:0]  m_size;
  logic [63:0] m_addr, m_wdata;
  logic [31:0] m_rdata, s_addr, s_wdata, s_rdata;
  logic        s_req, s_wr, s_addr_ok, s_data_ok, proto_err;
  logic [1:0]  s_size;
  logic [2:0]  outs_cnt;

  int n_vec = 0;
  int n_err = 0;

  sram_like_arbiter dut (
    .clk(clk), .resetn(resetn),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .outs_cnt(outs_cnt), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic        aok, dok;
    logic [31:0] rdata;
    logic [1:0]  e_aok, e_dok;
    logic        e_sreq;
    logic [31:0] e_saddr;
    logic [2:0]  e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] req, input logic aok, input logic dok,
                     input logic [31:0] rd, input logic [1:0] e_aok, input logic [1:0] e_dok,
                     input logic e_sreq, input logic [31:0] e_saddr, input logic [2:0] e_cnt,
                     input logic e_err);
    vec_t v;
    v.req = req; v.aok = aok; v.dok = dok; v.rdata = rd;
    v.e_aok = e_aok; v.e_dok = e_dok; v.e_sreq = e_sreq; v.e_saddr = e_saddr;
    v.e_cnt = e_cnt; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (vec %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Bus model: m0 = addr 0x1000 read size 2, m1 = addr 0x2000 write size 1.
  function automatic logic [31:0] exp_wdata(input logic [31:0] a);
    return (a == 32'h1000) ? 32'hAAAA0001 : (a == 32'h2000) ? 32'hBBBB0002 : 32'h0;
  endfunction
  function automatic logic exp_wr(input logic [31:0] a);
    return (a == 32'h2000);
  endfunction
  function automatic logic [1:0] exp_size(input logic [31:0] a);
    return (a == 32'h1000) ? 2'd2 : (a == 32'h2000) ? 2'd1 : 2'd0;
  endfunction

  task automatic check_vec(input int i, input vec_t v);
    n_vec++;
    chk("m_addr_ok", i, 32'(m_addr_ok), 32'(v.e_aok));
    chk("m_data_ok", i, 32'(m_data_ok), 32'(v.e_dok));
    chk("s_req",     i, 32'(s_req),     32'(v.e_sreq));
    chk("s_addr",    i, s_addr,         v.e_saddr);
    chk("s_wdata",   i, s_wdata,        exp_wdata(v.e_saddr));
    chk("s_wr",      i, 32'(s_wr),      32'(exp_wr(v.e_saddr)));
    chk("s_size",    i, 32'(s_size),    32'(exp_size(v.e_saddr)));
    chk("outs_cnt",  i, 32'(outs_cnt),  32'(v.e_cnt));
    chk("proto_err", i, 32'(proto_err), 32'(v.e_err));
    if (v.e_dok != 2'b00) chk("m_rdata", i, m_rdata, v.rdata);
  endtask

  localparam logic [31:0] A0 = 32'h1000, A1 = 32'h2000, BEEF = 32'hDEADBEEF;

  initial begin
    vec_t v;
    resetn = 1'b0; m_req = 2'b01; s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = '0;
    m_wr = 2'b10; m_size = {2'd1, 2'd2};
    m_addr = {32'h2000, 32'h1000}; m_wdata = {32'hBBBB0002, 32'hAAAA0001};

    // outs_cnt / proto_err columns are the state before the sampling cycle's edge.
    add(2'b00,0,0,0,    2'b00,2'b00,0,0, 0,0);            // idle
    add(2'b01,1,0,0,    2'b01,2'b00,1,A0,0,0);            // single accept
    add(2'b00,0,0,0,    2'b00,2'b00,0,0, 1,0);
    add(2'b00,0,1,BEEF, 2'b00,2'b01,0,0, 1,0);            // response
    add(2'b00,0,0,0,    2'b00,2'b00,0,0, 0,0);
    add(2'b11,1,0,0,    RR?2'b10:2'b01,2'b00,1,RR?A1:A0,0,0);  // contention
    add(2'b11,1,0,0,    2'b01,2'b00,1,A0,1,0);
    add(2'b11,1,0,0,    RR?2'b10:2'b01,2'b00,1,RR?A1:A0,2,0);
    add(2'b00,0,1,32'h11, 2'b00,RR?2'b10:2'b01,0,0,3,0);
    add(2'b00,0,1,32'h22, 2'b00,2'b01,0,0,2,0);
    add(2'b00,0,1,32'h33, 2'b00,RR?2'b10:2'b01,0,0,1,0);
    add(2'b00,0,0,0,    2'b00,2'b00,0,0, 0,0);
    add(2'b10,0,0,0,    2'b00,2'b00,1,A1,0,0);            // lock on m1
    add(2'b10,0,0,0,    2'b00,2'b00,1,A1,0,0);
    add(2'b10,0,0,0,    2'b00,2'b00,1,A1,0,0);
    add(2'b11,0,0,0,    2'b00,2'b00,1,A1,0,0);            // m0 arrives, lock holds
    add(2'b11,1,0,0,    2'b10,2'b00,1,A1,0,0);
    add(2'b11,1,0,0,    2'b01,2'b00,1,A0,1,0);
    add(2'b00,0,1,32'h44, 2'b00,2'b10,0,0,2,0);
    add(2'b00,0,1,32'h55, 2'b00,2'b01,0,0,1,0);
    add(2'b00,0,0,0,    2'b00,2'b00,0,0, 0,0);
    add(2'b01,1,0,0,    2'b01,2'b00,1,A0,0,0);            // ordering m0,m1,m0
    add(2'b10,1,0,0,    2'b10,2'b00,1,A1,1,0);
    add(2'b01,1,0,0,    2'b01,2'b00,1,A0,2,0);
    add(2'b00,0,1,32'h66, 2'b00,2'b01,0,0,3,0);
    add(2'b00,0,1,32'h77, 2'b00,2'b10,0,0,2,0);
    add(2'b00,0,1,32'h88, 2'b00,2'b01,0,0,1,0);
    add(2'b00,0,0,0,    2'b00,2'b00,0,0, 0,0);
    for (int k = 0; k < 4; k++)
      add(2'b01,1,0,0,  2'b01,2'b00,1,A0,3'(k),0);        // fill to MAX_OUTS
    add(2'b01,1,0,0,    2'b00,2'b00,0,0, 4,0);            // full: no accept
    add(2'b01,1,1,32'h99, 2'b00,2'b01,0,0,4,0);           // pop does not bypass
    add(2'b01,1,0,0,    2'b01,2'b00,1,A0,3,0);
    add(2'b00,0,0,0,    2'b00,2'b00,0,0, 4,0);
    for (int k = 0; k < 4; k++)
      add(2'b00,0,1,32'hA0+k, 2'b00,2'b01,0,0,3'(4-k),0);
    add(2'b00,0,0,0,    2'b00,2'b00,0,0, 0,0);
    add(2'b00,0,1,32'hBB, 2'b00,2'b00,0,0,0,0);           // data_ok while empty
    add(2'b00,0,0,0,    2'b00,2'b00,0,0, 0,1);
    add(2'b00,0,0,0,    2'b00,2'b00,0,0, 0,1);            // sticky

    // In reset with live request/response inputs: everything quiet.
    #3;
    n_vec++;
    chk("rst m_addr_ok", -1, 32'(m_addr_ok), 0);
    chk("rst m_data_ok", -1, 32'(m_data_ok), 0);
    chk("rst s_req",     -1, 32'(s_req), 0);
    chk("rst outs_cnt",  -1, 32'(outs_cnt), 0);
    chk("rst proto_err", -1, 32'(proto_err), 0);

    @(negedge clk);
    m_req = '0; s_addr_ok = 0; s_data_ok = 0;
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clk);
      m_req = v.req; s_addr_ok = v.aok; s_data_ok = v.dok; s_rdata = v.rdata;
      #2;
      check_vec(i, v);
    end

    // Mid-stream reset with two outstanding and proto_err still set.
    @(negedge clk); m_req = 2'b01; s_addr_ok = 1; s_data_ok = 0;
    @(negedge clk);
    @(negedge clk); m_req = 2'b00; s_addr_ok = 0;
    #2;
    n_vec++;
    chk("pre-rst outs_cnt",  100, 32'(outs_cnt), 2);
    chk("pre-rst proto_err", 100, 32'(proto_err), 1);
    m_req = 2'b01; s_addr_ok = 1; s_data_ok = 1;
    #1 resetn = 1'b0;
    #1;
    n_vec++;
    chk("midrst m_addr_ok", 101, 32'(m_addr_ok), 0);
    chk("midrst m_data_ok", 101, 32'(m_data_ok), 0);
    chk("midrst s_req",     101, 32'(s_req), 0);
    chk("midrst outs_cnt",  101, 32'(outs_cnt), 0);
    chk("midrst proto_err", 101, 32'(proto_err), 0);
    @(negedge clk); m_req = 2'b00; s_addr_ok = 0; s_data_ok = 0;
    resetn = 1'b1;
    @(negedge clk); m_req = 2'b10; s_addr_ok = 1;
    #2;
    n_vec++;
    chk("post-rst m_addr_ok", 102, 32'(m_addr_ok), 32'(2'b10));
    chk("post-rst s_addr",    102, s_addr, A1);
    @(negedge clk); m_req = 2'b00; s_addr_ok = 0;
    #2;
    n_vec++;
    chk("post-rst outs_cnt",  103, 32'(outs_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
